ifetch_prefetch_buffer: RTL and testbench
=========================================

# ifetch_prefetch_buffer

Parametrised instruction-fetch front end for the next-generation RV32I core. It replaces the single-cycle PC-register-plus-combinational-instruction-ROM arrangement, for use in pipelined and multi-cycle variants:
- owns the fetch PC and issues word requests to an instruction memory over a valid/ready request channel with variable-latency, in-order responses;
- buffers fetched instructions in a DEPTH-entry FIFO with their PCs;
- flushes and re-steers on a branch/jump redirect from execute.

## Interface
Parameters:
- XLEN, 32: PC/address width.
- DEPTH, 4: FIFO entries; power of 2, ≥2. Also bounds requests in flight plus buffered entries.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge).
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address; bits [1:0] always 0.
- imem_rsp_valid  in  1  one response word this cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  flush and re-steer; single-cycle pulse.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0).
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  consumer pops head when instr_valid && instr_ready.
- instr  out  32  head instruction.
- instr_pc  out  XLEN  PC of head instruction.
- occupancy  out  $clog2(DEPTH+1)  buffered entries.

## Operation
- State:
  - fetch_pc;
  - FIFO (wr_ptr, rd_ptr, count);
  - outstanding: requests accepted, responses not yet returned;
  - drop_cnt: in-flight responses to discard.
- Issue: imem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept: fetch_pc += 4 and outstanding += 1.
  - Address stays stable until the request is accepted or a redirect occurs.
- Response: each accepted request yields exactly one response, in order, at least 1 cycle after acceptance.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Otherwise: push {imem_rsp_data, pc} to the FIFO. The pc is tracked by a separate rsp_pc register, advanced by 4 per non-dropped response.
  - outstanding decrements on every response.
- Pop: when instr_valid && instr_ready, rd_ptr advances.
  - Push and pop in the same cycle leave count unchanged.
- Redirect has priority over all other events in its cycle:
  - FIFO cleared (count = 0, pointers to 0); any pop that cycle is ignored.
  - fetch_pc and rsp_pc take redirect_pc & ~3.
  - drop_cnt takes outstanding − imem_rsp_valid; a response arriving in the redirect cycle is itself discarded.
  - imem_req_valid is 0 in the redirect cycle.
- Back-to-back redirects: the last one wins. drop_cnt is recomputed from outstanding each time.
- fetch_pc wraps modulo 2^XLEN with no error.

## Timing
- Reset (rst = 0 at edge):
  - fetch_pc = rsp_pc = RESET_PC; count = outstanding = drop_cnt = 0.
  - Outputs: imem_req_valid = 0, instr_valid = 0, occupancy = 0; instr and instr_pc are don't-care.
  - Reset mid-operation abandons in-flight responses. The memory is reset on the same rst.
- First request: imem_req_valid = 1 in the first cycle with rst = 1. A 1-cycle-latency memory gives instr_valid 2 cycles after request acceptance (registered FIFO).
- Full: when count + outstanding = DEPTH, imem_req_valid = 0. It reasserts the cycle after a pop, with no combinational path from instr_ready to imem_req_valid.
- Empty: instr_valid = 0; instr and instr_pc hold their last values.
- After a redirect at cycle N: request to the new pc at N+1; first new instruction valid at N+1 + memory latency + 1, once drops complete.

## Configuration
- IFETCH_BYPASS_EN defined:
  - When the FIFO is empty, drop_cnt = 0 and imem_rsp_valid = 1, the response appears combinationally on instr/instr_pc with instr_valid = 1 in the same cycle.
  - If instr_ready = 1, it is consumed without being written. Otherwise it is written as normal.
  - Saves one cycle of latency.
- Undefined: responses are always written first, giving the 1-cycle registered latency above.
- Both builds must pass the same test plan, with latency checks adjusted by one cycle.

## Test plan
- Reset, then 1-cycle memory, instr_ready = 1 → requests at 0x0, 0x4, 0x8…; instr_pc sequence 0x0, 0x4, 0x8 with matching words; occupancy ≤ 1.
- instr_ready = 0, DEPTH = 4 → exactly 4 requests accepted; imem_req_valid stays low; occupancy = 4. One pop → exactly one further request.
- 3-cycle memory, 3 in flight, redirect_pc = 0x103 → the 3 old responses are discarded; next request 0x100; first output instr_pc = 0x100.
- Redirect in the same cycle as a pop and a response → FIFO empty next cycle; response discarded; no old PC is ever output afterwards.
- imem_req_ready held 0 for 5 cycles → imem_req_addr stable throughout; accepted exactly once.
- rst asserted with 2 in flight and a full FIFO → all outputs at reset values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// ifetch_prefetch_buffer
//
// Instruction-fetch front end. It owns the fetch PC and issues word requests
// to an instruction memory with variable-latency, in-order responses. Returned
// words are buffered with their PCs in a DEPTH-entry FIFO. A redirect from
// execute flushes the FIFO and re-steers fetch. Responses for requests that
// were already in flight at the redirect are counted and discarded.
//
// Optional feature macro: IFETCH_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty and nothing is
//   being dropped is presented combinationally on instr/instr_pc. This saves
//   one cycle of fetch latency.
//
// Parameters:
//   XLEN     - PC / address width
//   DEPTH    - FIFO entries (power of 2, >= 2); also caps buffered + in-flight
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous reset, active low
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  word-aligned fetch address
//   imem_rsp_valid  in   response word valid (one per accepted request, in order)
//   imem_rsp_data   in   response instruction word
//   redirect_valid  in   flush and re-steer (single-cycle pulse)
//   redirect_pc     in   new fetch address (bits [1:0] ignored)
//   instr_valid     out  head instruction valid
//   instr_ready     in   consumer takes head when instr_valid && instr_ready
//   instr           out  head instruction word
//   instr_pc        out  PC of head instruction
//   occupancy       out  number of buffered entries
// -----------------------------------------------------------------------------
module ifetch_prefetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [XLEN-1:0]            instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    // FIFO storage (no reset needed; validity is tracked by count_q)
    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    // Last presented head, so instr/instr_pc hold while the FIFO is empty
    logic [31:0]     last_instr_q;
    logic [XLEN-1:0] last_pc_q;

    logic [CW:0]     slots_used;
    logic            req_fire;
    logic            rsp_live;
    logic            bypass;
    logic            fifo_push;
    logic            fifo_pop;
    logic [XLEN-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

    // Capacity is judged only from registered state, so instr_ready has no
    // combinational path to imem_req_valid.
    assign slots_used     = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = rst && !redirect_valid && (slots_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when no stale responses remain to be dropped.
    assign rsp_live = imem_rsp_valid && (drop_cnt_q == '0);

`ifdef IFETCH_BYPASS_EN
    assign bypass = rsp_live && (count_q == '0) && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = (count_q != '0) || bypass;
    assign occupancy   = count_q;

    always_comb begin
        instr    = last_instr_q;
        instr_pc = last_pc_q;
        if (count_q != '0) begin
            instr    = data_mem[rd_ptr_q];
            instr_pc = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            instr    = imem_rsp_data;
            instr_pc = rsp_pc_q;
        end
    end

    // A bypassed word that is consumed immediately is never written.
    assign fifo_pop  = (count_q != '0) && instr_ready && !redirect_valid;
    assign fifo_push = rsp_live && !redirect_valid && !(bypass && instr_ready);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        drop_cnt_d    = drop_cnt_q;
        // No request is issued in a redirect cycle, so this is also the
        // post-redirect outstanding count.
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight, including a response landing now,
            // belongs to the old path.
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_live) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && fifo_push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
        if (instr_valid) begin
            last_instr_q <= instr;
            last_pc_q    <= instr_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
module tb_ifetch_prefetch_buffer;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH+1);
`ifdef IFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic            clk;
    logic            rst;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic [CW-1:0]   occupancy;

    ifetch_prefetch_buffer #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: pending responses, in order. 'stale' marks requests the
    // bench knows belong to a flushed path.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } mem_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mem_t        mem_q[$];
    exp_t        exp_q[$];      // scoreboard: instructions the consumer must see, in order
    logic [31:0] acc_log[$];    // addresses of accepted requests
    logic [31:0] pc_log[$];     // PCs consumed at the output
    logic [31:0] model_pc;
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          n_accept = 0;
    int          first_valid_cyc = -1;
    bit          in_reset = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // One clock cycle of stimulus plus issue-side model update.
    task automatic step(input bit rst_v, input bit rdy, input bit reqrdy,
                        input bit redir, input logic [31:0] rpc, input int lat);
        bit rsp_now;
        int stale;
        int live;
        @(negedge clk);
        cyc++;
        rst            = rst_v;
        instr_ready    = rdy;
        imem_req_ready = reqrdy;
        redirect_valid = redir && rst_v;
        redirect_pc    = rpc;
        rsp_now        = rst_v && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_q[0].data : $urandom;
        #1;
        if (!rst_v) begin
            if (in_reset) begin
                chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
                chk("rst_instr_valid", 64'(instr_valid), 64'd0);
                chk("rst_occupancy", 64'(occupancy), 64'd0);
            end
            in_reset = 1;
            mem_q.delete();
            exp_q.delete();
            model_pc = RESET_PC;
        end else begin
            in_reset = 0;
            stale = 0;
            foreach (mem_q[i]) if (mem_q[i].stale) stale++;
            live = mem_q.size() - stale;
            // Buffered + live in flight + stale in flight must stay below DEPTH.
            chk("req_valid", 64'(imem_req_valid),
                64'(!redirect_valid && (exp_q.size() + stale < DEPTH)));
            chk("occupancy", 64'(occupancy), 64'(exp_q.size() - live));
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", 64'(imem_req_addr), 64'(model_pc));
                n_accept++;
                acc_log.push_back(imem_req_addr);
                exp_q.push_back('{pc: model_pc, data: word_of(model_pc)});
                mem_q.push_back('{addr: model_pc, data: word_of(model_pc),
                                  due: cyc + lat, stale: 1'b0});
                model_pc = model_pc + 32'd4;
            end
            if (rsp_now) void'(mem_q.pop_front());
            if (redirect_valid) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                model_pc = {rpc[31:2], 2'b00};
            end
        end
    endtask

    // Monitor: consumes outputs whenever a handshake happens and compares
    // against the scoreboard. Pops in a redirect cycle are ignored by design.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b1 && instr_valid === 1'b1 && first_valid_cyc < 0)
            first_valid_cyc = cyc;
        if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 &&
            redirect_valid === 1'b0) begin
            pc_log.push_back(instr_pc);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_instr: got pc %0h expected none (cycle %0d)", instr_pc, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("instr_pc", 64'(instr_pc), 64'(e.pc));
                chk("instr", 64'(instr), 64'(e.data));
            end
        end
    end

    task automatic chk_log(input string name, input int idx, input logic [31:0] expv, input bit use_acc);
        if (use_acc ? (acc_log.size() > idx) : (pc_log.size() > idx))
            chk(name, 64'(use_acc ? acc_log[idx] : pc_log[idx]), 64'(expv));
        else begin
            checks++;
            $display("FAIL %s: got no entry expected %0h", name, expv);
        end
    endtask

    initial begin : stim
        int c0;
        int a0;
        int p0;
        logic [31:0] addr0;
        logic [31:0] rpc;
        rst = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Reset, then streaming with a 1-cycle memory
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        first_valid_cyc = -1;
        c0 = cyc + 1;
        for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0, 1);
        chk("first_latency", 64'(first_valid_cyc - c0), 64'(2 - BYP));
        chk_log("first_pc", 0, RESET_PC, 0);
        chk_log("second_pc", 1, RESET_PC + 32'd4, 0);

        // Fill with consumer stalled, then a single pop allows one more request
        for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0, 1);
        chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
        chk("full_req_low", 64'(imem_req_valid), 64'd0);
        a0 = n_accept;
        step(1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 1);
        chk("one_refill", 64'(n_accept - a0), 64'd1);

        // Redirect with 3 requests in flight on a 3-cycle memory
        step(0, 0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 3);
        a0 = n_accept;
        p0 = pc_log.size();
        step(1, 0, 1, 1, 32'h0000_0103, 3);
        for (int i = 0; i < 15; i++) step(1, 1, 1, 0, 0, 3);
        chk_log("redir_req_addr", a0, 32'h0000_0100, 1);
        chk_log("redir_first_pc", p0, 32'h0000_0100, 0);

        // Redirect coinciding with a pop and a response
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) step(1, 0, 1, 0, 0, 1);
        p0 = pc_log.size();
        step(1, 1, 1, 1, 32'h0000_0200, 1);
        chk("redir_pre_pop", 64'(instr_valid), 64'd1);
        chk("redir_pre_rsp", 64'(imem_rsp_valid), 64'd1);
        step(1, 1, 1, 0, 0, 1);
        chk("flush_empty_valid", 64'(instr_valid), 64'd0);
        chk("flush_empty_occ", 64'(occupancy), 64'd0);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 1);
        chk_log("flush_first_pc", p0, 32'h0000_0200, 0);

        // Memory not ready for 5 cycles: address must hold, one acceptance
        step(1, 1, 0, 0, 0, 1);
        addr0 = imem_req_addr;
        a0 = n_accept;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 1);
            chk("stall_addr", 64'(imem_req_addr), 64'(addr0));
        end
        step(1, 1, 1, 0, 0, 1);
        chk("stall_accept_once", 64'(n_accept - a0), 64'd1);
        chk_log("stall_accept_addr", a0, addr0, 1);

        // Randomised traffic, including redirects near the top of the address space
        for (int i = 0; i < 1500; i++) begin
            bit rd;
            rd  = ($urandom_range(0, 99) < 3);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            step(1, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 75),
                 rd, rpc, int'($urandom_range(1, 4)));
        end

        // Reset mid-operation with requests in flight and data buffered
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 3);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        a0 = n_accept;
        p0 = pc_log.size();
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 1);
        chk_log("restart_addr", a0, RESET_PC, 1);
        chk_log("restart_pc", p0, RESET_PC, 0);

        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
